keypad_matrix_scanner: RTL and testbench
========================================

// Module: keypad_matrix_scanner
// PURPOSE
//  Parametrised successor of the 4x4 keypad scanner: drives NUM_ROWS active-low
//  rows, samples NUM_COLS active-low columns and debounces across whole scan frames.
//  Emits a one-cycle press event with the raw key index, a one-cycle release event,
//  a held level and a multi-key (ghosting) flag.
//  Has an internal scan prescaler, so no external clock divider is needed.
//  Sits between the keypad pins and the display/command logic.
// PARAMETERS
//  NUM_ROWS  4      rows driven (>=2)
//  NUM_COLS  4      columns sampled (>=2)
//  SCAN_DIV  25000  clk cycles per row step (>=4, covers sync latency + settling)
//  DEBOUNCE  4      consecutive identical frames needed to accept a press/release (>=1)
//  CODE_W    localparam = $clog2(NUM_ROWS*NUM_COLS)
// PORTS
//  clk          in   1         system clock
//  reset        in   1         synchronous, active-high reset
//  keypadCol    in   NUM_COLS  column inputs, 0 = key closed on driven row
//  keypadRow    out  NUM_ROWS  row drive, one bit low at a time
//  key_code     out  CODE_W    index of accepted key = row*NUM_COLS + col; holds value
//  key_valid    out  1         1-cycle pulse on accepted press
//  key_release  out  1         1-cycle pulse on accepted release
//  key_held     out  1         high from key_valid until key_release
//  multi_key    out  1         last frame saw >1 closed key
// BEHAVIOUR
//  Reset (synchronous on clk, active-high): keypadRow=all 1s, key_code=0,
//   key_valid=key_release=key_held=multi_key=0, prescaler=0, row index=0, FSM=IDLE.
//   All pending debounce state is discarded, and no pulse fires on reset.
//  Columns pass through a 2-FF synchroniser. Row index r drives keypadRow=~(1<<r),
//   starting the first cycle after reset deasserts.
//  Prescaler counts 0..SCAN_DIV-1. When it reaches SCAN_DIV-1 (tick), the synced
//   columns are stored for row r, then r advances and wraps NUM_ROWS-1 -> 0.
//  Frame end is the tick at r=NUM_ROWS-1. Frame length = NUM_ROWS*SCAN_DIV cycles.
//   Frame result is NONE (0 keys), ONE(c) (exactly 1 key, index c) or MULTI (>1 key).
//   multi_key is updated at every frame end and equals (result==MULTI).
//  FSM is evaluated only at frame end; cnt is the frame counter.
//   IDLE:   ONE(c) -> cand=c, cnt=1. If DEBOUNCE==1 accept immediately, else go
//           to DB_PRESS. NONE/MULTI -> stay in IDLE.
//   DB_PRESS: ONE(cand) -> cnt+1. When cnt reaches DEBOUNCE -> PRESSED and accept.
//           Any other result -> IDLE.
//   accept: key_code<=cand, key_valid=1 for the next cycle only, key_held<=1.
//   PRESSED: ONE(key_code) -> stay. Any other result (NONE, other key, MULTI)
//           -> cnt=1, then DB_REL, or release immediately if DEBOUNCE==1.
//   DB_REL: non-matching result -> cnt+1. When cnt reaches DEBOUNCE -> IDLE and
//           release. ONE(key_code) -> PRESSED (press is not re-reported).
//   release: key_release=1 for one cycle, key_held<=0, key_code is retained.
//  Latency: key_valid/key_release assert 1 clk after the deciding frame-end tick.
//  Key change without release: goes through DB_REL -> IDLE and emits key_release.
//   The new key then needs its own DEBOUNCE frames. key_valid and key_release
//   never assert in the same cycle.
//  Counters saturate and cannot wrap: cnt is bounded by DEBOUNCE, prescaler by SCAN_DIV.
// TESTING (NUM_ROWS=4, NUM_COLS=4, SCAN_DIV=4, DEBOUNCE=3; frame = 16 clk)
//  1 reset=1 for 3 clk -> keypadRow=4'b1111, all outputs 0.
//    First clk after release -> keypadRow=4'b1110, then 1101 after 4 clk.
//  2 Hold row2/col1 (keypadCol=4'b1101 while keypadRow==4'b1011) -> exactly one
//    key_valid pulse with key_code=9, 1 clk after 3rd full frame end; key_held=1.
//  3 Release from held -> key_release pulse 1 clk after 3rd empty frame end.
//    key_held=0, key_code stays 9, no further key_valid.
//  4 Bounce: key 5 for 2 frames, NONE for 1 frame, key 5 again -> no key_valid until
//    3 consecutive key-5 frames are counted from the re-press.
//  5 Keys 0 and 7 together -> multi_key=1 at frame end, no key_valid.
//    Drop key 7 -> multi_key=0 next frame, key_valid with key_code=0 after 3 frames.
//  6 reset=1 while PRESSED (key 9) -> next clk: key_held=0, keypadRow=4'b1111,
//    no key_release pulse. After release with key still down -> fresh key_valid code 9.

Source files
------------

// File: rtl/keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_matrix_scanner
// Description : Row-scanning matrix keypad controller. Drives NUM_ROWS
//               active-low rows one at a time, samples NUM_COLS active-low
//               columns through a 2-FF synchroniser, assembles whole scan
//               frames and debounces press/release over DEBOUNCE frames.
// Ports       : clk         - system clock
//               reset       - synchronous active-high reset
//               keypadCol   - column inputs, 0 = key closed on driven row
//               keypadRow   - row drive, one bit low at a time
//               key_code    - row*NUM_COLS+col of the accepted key (held)
//               key_valid   - 1-cycle pulse on accepted press
//               key_release - 1-cycle pulse on accepted release
//               key_held    - high from key_valid until key_release
//               multi_key   - last frame contained more than one closed key
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_matrix_scanner #(
  parameter int NUM_ROWS = 4,
  parameter int NUM_COLS = 4,
  parameter int SCAN_DIV = 25000,
  parameter int DEBOUNCE = 4,
  localparam int CODE_W  = $clog2(NUM_ROWS * NUM_COLS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_COLS-1:0] keypadCol,
  output logic [NUM_ROWS-1:0] keypadRow,
  output logic [CODE_W-1:0]   key_code,
  output logic                key_valid,
  output logic                key_release,
  output logic                key_held,
  output logic                multi_key
);

  localparam int ROW_W   = $clog2(NUM_ROWS);
  localparam int PRESC_W = $clog2(SCAN_DIV);
  localparam int CNT_W   = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
  localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(NUM_ROWS - 1);
  // The frame that brings cnt from DEBOUNCE-1 to DEBOUNCE is the deciding one.
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DB_PRESS = 2'd1;
  localparam logic [1:0] S_PRESSED  = 2'd2;
  localparam logic [1:0] S_DB_REL   = 2'd3;

  // Synchroniser and scan timing
  logic [NUM_COLS-1:0] col_meta_q, col_sync_q;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [NUM_ROWS-1:0] row_drv_q;
  // Closed-key map of the frame being assembled (1 = closed)
  logic [NUM_ROWS-1:0][NUM_COLS-1:0] frame_q;

  // Debounce FSM
  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CODE_W-1:0] cand_q, cand_d;

  // Outputs
  logic [CODE_W-1:0] key_code_q;
  logic              valid_q, release_q, held_q, multi_q;

  logic              w_tick, w_fend;
  logic [1:0]        w_nkeys;
  logic [CODE_W-1:0] w_idx;
  logic              w_one, w_multi, w_match_cand, w_match_code;
  logic              w_accept, w_release;

  assign w_tick = (presc_q == PRESC_LAST);
  assign w_fend = w_tick && (row_q == ROW_LAST);

  assign presc_d = w_tick ? '0 : presc_q + PRESC_W'(1);
  assign row_d   = !w_tick ? row_q : ((row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1));

  // Frame classification. The row currently being sampled is taken straight
  // from the synchroniser so the frame-end tick sees the complete frame.
  // w_nkeys saturates at 2, which is all that NONE/ONE/MULTI needs.
  always_comb begin
    w_nkeys = 2'd0;
    w_idx   = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        if ((ROW_W'(r) == row_q) ? !col_sync_q[c] : frame_q[r][c]) begin
          if (w_nkeys == 2'd0) w_idx = CODE_W'(r * NUM_COLS + c);
          if (w_nkeys != 2'd2) w_nkeys = w_nkeys + 2'd1;
        end
      end
    end
  end

  assign w_one        = (w_nkeys == 2'd1);
  assign w_multi      = (w_nkeys == 2'd2);
  assign w_match_cand = w_one && (w_idx == cand_q);
  assign w_match_code = w_one && (w_idx == key_code_q);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
    end
  end

  // FSM: next-state logic, evaluated only at frame end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    if (w_fend) begin
      case (state_q)
        S_IDLE: begin
          if (w_one) begin
            cand_d  = w_idx;
            cnt_d   = CNT_ONE;
            state_d = w_accept ? S_PRESSED : S_DB_PRESS;
          end
        end
        S_DB_PRESS: begin
          if (!w_match_cand)     state_d = S_IDLE;
          else if (w_accept)     state_d = S_PRESSED;
          else if (cnt_q < CNT_LAST) cnt_d = cnt_q + CNT_ONE;
        end
        S_PRESSED: begin
          if (!w_match_code) begin
            cnt_d   = CNT_ONE;
            state_d = w_release ? S_IDLE : S_DB_REL;
          end
        end
        S_DB_REL: begin
          // A returning key resumes PRESSED silently; no second key_valid.
          if (w_match_code)      state_d = S_PRESSED;
          else if (w_release)    state_d = S_IDLE;
          else if (cnt_q < CNT_LAST) cnt_d = cnt_q + CNT_ONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM: output decode (press/release decisions on the frame-end tick)
  always_comb begin
    w_accept  = 1'b0;
    w_release = 1'b0;
    if (w_fend) begin
      case (state_q)
        S_IDLE:     w_accept  = w_one && (DEBOUNCE == 1);
        S_DB_PRESS: w_accept  = w_match_cand && (cnt_q >= CNT_LAST);
        S_PRESSED:  w_release = !w_match_code && (DEBOUNCE == 1);
        S_DB_REL:   w_release = !w_match_code && (cnt_q >= CNT_LAST);
        default: begin
          w_accept  = 1'b0;
          w_release = 1'b0;
        end
      endcase
    end
  end

  // Scan datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      col_meta_q <= '1;
      col_sync_q <= '1;
      presc_q    <= '0;
      row_q      <= '0;
      row_drv_q  <= '1;
      frame_q    <= '0;
      key_code_q <= '0;
      valid_q    <= 1'b0;
      release_q  <= 1'b0;
      held_q     <= 1'b0;
      multi_q    <= 1'b0;
    end else begin
      col_meta_q <= keypadCol;
      col_sync_q <= col_meta_q;
      presc_q    <= presc_d;
      row_q      <= row_d;
      row_drv_q  <= ~(NUM_ROWS'(1) << row_d);
      if (w_tick) frame_q[row_q] <= ~col_sync_q;
      if (w_fend) multi_q <= w_multi;
      valid_q   <= w_accept;
      release_q <= w_release;
      if (w_accept) begin
        key_code_q <= w_idx;
        held_q     <= 1'b1;
      end else if (w_release) begin
        held_q     <= 1'b0;
      end
    end
  end

  assign keypadRow   = row_drv_q;
  assign key_code    = key_code_q;
  assign key_valid   = valid_q;
  assign key_release = release_q;
  assign key_held    = held_q;
  assign multi_key   = multi_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_matrix_scanner
// Description : Scoreboard bench for keypad_matrix_scanner (4x4, SCAN_DIV=4,
//               DEBOUNCE=3). A keypad model turns a pressed-key mask into
//               column levels; a frame-level reference model predicts the
//               outputs at every frame end and a monitor compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_matrix_scanner;

  localparam int NR    = 4;
  localparam int NC    = 4;
  localparam int SD    = 4;
  localparam int DB    = 3;
  localparam int FRAME = NR * SD;

  logic          clk = 1'b0;
  logic          reset;
  logic [NC-1:0] keypadCol;
  logic [NR-1:0] keypadRow;
  logic [3:0]    key_code;
  logic          key_valid, key_release, key_held, multi_key;

  logic [NR*NC-1:0] keys;   // bit k = key k physically closed

  keypad_matrix_scanner #(
    .NUM_ROWS(NR), .NUM_COLS(NC), .SCAN_DIV(SD), .DEBOUNCE(DB)
  ) dut (
    .clk(clk), .reset(reset), .keypadCol(keypadCol), .keypadRow(keypadRow),
    .key_code(key_code), .key_valid(key_valid), .key_release(key_release),
    .key_held(key_held), .multi_key(multi_key)
  );

  always #5 clk = ~clk;

  // Passive switch matrix: a closed key pulls its column low while its row is driven low
  always_comb begin
    keypadCol = '1;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        if (!keypadRow[r] && keys[r*NC+c]) keypadCol[c] = 1'b0;
  end

  int cyc;  // posedges since reset deasserted
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    int       cyc;
    bit       v;
    bit       r;
    bit       h;
    bit       m;
    int       code;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at t=%0t: actual=%0d required=%0d", name, $time, act, req);
    end
  endtask

  // Frame-level reference model
  bit m_held;
  int m_code, m_cand, m_cnt, m_miss, frame_no;

  task automatic model_reset();
    m_held = 0; m_code = 0; m_cand = 0; m_cnt = 0; m_miss = 0; frame_no = 0;
  endtask

  // Apply a key mask for the coming frame and queue the frame-end prediction.
  task automatic frame_begin(input logic [NR*NC-1:0] mask);
    exp_t e;
    int   n, idx;
    keys = mask;
    n    = $countones(mask);
    idx  = 0;
    for (int k = NR*NC-1; k >= 0; k--) if (mask[k]) idx = k;
    e.v = 0; e.r = 0;
    if (!m_held) begin
      if (n == 1 && m_cnt > 0 && idx == m_cand) m_cnt++;
      else if (n == 1 && m_cnt == 0) begin m_cand = idx; m_cnt = 1; end
      else m_cnt = 0;
      if (m_cnt == DB) begin
        e.v = 1; m_held = 1; m_code = idx; m_cnt = 0; m_miss = 0;
      end
    end else begin
      if (n == 1 && idx == m_code) m_miss = 0;
      else m_miss++;
      if (m_miss == DB) begin
        e.r = 1; m_held = 0; m_cnt = 0;
      end
    end
    frame_no++;
    e.cyc  = frame_no * FRAME;
    e.h    = m_held;
    e.m    = (n > 1);
    e.code = m_code;
    sb.push_back(e);
  endtask

  task automatic run_frames(input logic [NR*NC-1:0] mask, input int nframes);
    for (int i = 0; i < nframes; i++) begin
      frame_begin(mask);
      repeat (FRAME) @(negedge clk);
    end
  endtask

  // Monitor: pops the prediction for each frame end and compares
  always @(negedge clk) begin
    exp_t e;
    if (!reset && cyc > 0) begin
      if (key_valid && key_release) check("valid_and_release_together", 1, 0);
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        total++; bad++;
        $display("FAIL event_timeout: frame end cyc=%0d never observed (now %0d)", sb[0].cyc, cyc);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        check("key_valid",   key_valid,   e.v);
        check("key_release", key_release, e.r);
        check("key_held",    key_held,    e.h);
        check("multi_key",   multi_key,   e.m);
        check("key_code",    key_code,    e.code);
      end else begin
        check("no_pulse_off_frame_end", key_valid | key_release, 0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NR*NC-1:0] m;
    int kind, len, a, b;
    model_reset();
    keys  = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_row",     keypadRow, 4'b1111);
    check("reset_code",    key_code, 0);
    check("reset_valid",   key_valid, 0);
    check("reset_release", key_release, 0);
    check("reset_held",    key_held, 0);
    check("reset_multi",   multi_key, 0);
    reset = 1'b0;

    // First frame is empty; check the row walk inside it.
    frame_begin('0);
    @(negedge clk);
    check("row_first", keypadRow, 4'b1110);
    repeat (4) @(negedge clk);
    check("row_second", keypadRow, 4'b1101);
    repeat (FRAME - 5) @(negedge clk);

    // Press and release key 9
    run_frames(16'(1) << 9, 4);
    run_frames('0, 4);
    // Bounce on key 5
    run_frames(16'(1) << 5, 2);
    run_frames('0, 1);
    run_frames(16'(1) << 5, 4);
    run_frames('0, 4);
    // Keys 0+7 together, then drop 7
    run_frames((16'(1) << 0) | (16'(1) << 7), 2);
    run_frames(16'(1) << 0, 4);
    run_frames('0, 4);
    // Key change without release: 9 -> 6
    run_frames(16'(1) << 9, 4);
    run_frames(16'(1) << 6, 7);
    run_frames('0, 4);
    // Release bounce: key returns during release debounce
    run_frames(16'(1) << 9, 3);
    run_frames('0, 2);
    run_frames(16'(1) << 9, 2);
    run_frames('0, 4);

    // Random segments
    for (int s = 0; s < 30; s++) begin
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 5);
      a    = $urandom_range(0, 15);
      b    = (a + $urandom_range(1, 15)) % 16;
      if (kind < 4)      m = '0;
      else if (kind < 9) m = 16'(1) << a;
      else               m = (16'(1) << a) | (16'(1) << b);
      run_frames(m, len);
    end
    run_frames('0, 4);

    // Reset while key 9 is held
    run_frames(16'(1) << 9, 3);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_held",    key_held, 0);
    check("midreset_row",     keypadRow, 4'b1111);
    check("midreset_release", key_release, 0);
    check("midreset_valid",   key_valid, 0);
    repeat (2) @(negedge clk);
    model_reset();
    reset = 1'b0;
    run_frames(16'(1) << 9, 4);
    run_frames('0, 4);

    @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
